// File: rtl/dmem_bus_bridge_if.sv
// dmem_bus_if: two-phase data bus between the bridge (master) and memory system (slave)
//   bus_req/bus_wr/bus_addr/bus_wstrb/bus_wdata : request phase, driven by master
//   bus_addr_ok                                  : request accepted
//   bus_rdata/bus_data_ok                        : data phase, read data or write response
interface dmem_bus_if;
    logic        bus_req;
    logic        bus_wr;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic [31:0] bus_rdata;
    logic        bus_data_ok;
    modport master (
        output bus_req, bus_wr, bus_addr, bus_wstrb, bus_wdata,
        input  bus_addr_ok, bus_rdata, bus_data_ok
    );
    modport slave (
        input  bus_req, bus_wr, bus_addr, bus_wstrb, bus_wdata,
        output bus_addr_ok, bus_rdata, bus_data_ok
    );
endinterface

// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: turns a single-cycle memory-stage request into a two-phase bus transaction
//   cpu_clk_50M, cpu_rst_n : clock (rising edge), asynchronous active-low reset
//   dce/daddr/we/din/dre   : data request from the memory stage
//   flush                  : exception/pipeline flush
//   stall_req              : holds the pipeline while a transaction is in flight
//   dout/dout_valid        : masked load data and its one-cycle write-back strobe
//   bus_err                : one-cycle pulse when a transaction times out
//   dbus                   : master side of the data bus
module dmem_bus_bridge #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    input  logic        dce,
    input  logic [31:0] daddr,
    input  logic [3:0]  we,
    input  logic [31:0] din,
    input  logic [3:0]  dre,
    input  logic        flush,
    output logic        stall_req,
    output logic [31:0] dout,
    output logic        dout_valid,
    output logic        bus_err,
    dmem_bus_if.master  dbus
);
    localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3;
    logic [1:0]       state_q, state_d;
    logic [31:0]      addr_q, addr_d, wdata_q, wdata_d, dout_q, dout_d;
    logic [3:0]       wstrb_q, wstrb_d, rmask_q, rmask_d;
    logic             wr_q, wr_d, drop_q, drop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy, done_ok, abort, drop_now, expire;
    logic [31:0]      rdata_m;
    always_comb begin
        busy     = state_q == S_REQ || state_q == S_WAIT;
        done_ok  = dbus.bus_data_ok && (state_q == S_WAIT || (state_q == S_REQ && dbus.bus_addr_ok));
        abort    = state_q == S_REQ && flush && !dbus.bus_addr_ok;
        // once the bus has accepted the request a flush only suppresses write-back
        drop_now = drop_q || (flush && (state_q == S_WAIT || (state_q == S_REQ && dbus.bus_addr_ok)));
        expire   = busy && cnt_q == CNT_W'(TIMEOUT - 1) && !done_ok && !abort;
        for (int i = 0; i < 4; i++) rdata_m[8*i +: 8] = rmask_q[i] ? dbus.bus_rdata[8*i +: 8] : 8'h00;
        state_d = state_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        rmask_d = rmask_q;
        dout_d  = dout_q;
        drop_d  = drop_q;
        cnt_d   = busy ? cnt_q + 1'b1 : '0;
        case (state_q)
            S_IDLE: if (dce && !flush) begin
                state_d = S_REQ;
                addr_d  = daddr & 32'hFFFF_FFFC;
                wr_d    = |we;
                wstrb_d = we;
                wdata_d = din;
                rmask_d = dre;
                drop_d  = 1'b0;
            end
            S_REQ:   state_d = abort ? S_IDLE : dbus.bus_addr_ok ? S_WAIT : S_REQ;
            S_WAIT:  state_d = S_WAIT;
            default: state_d = S_IDLE;
        endcase
        if (busy) drop_d = drop_now;
        if (done_ok || expire) begin
            state_d = drop_now ? S_IDLE : S_DONE;
            drop_d  = 1'b0;
        end
        if (done_ok && !wr_q && !drop_now) dout_d = rdata_m;
        if (expire) dout_d = '0;
    end
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wstrb_q <= '0;
            wdata_q <= '0;
            rmask_q <= '0;
            dout_q  <= '0;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            rmask_q <= rmask_d;
            dout_q  <= dout_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
        end
    end
    assign stall_req      = (state_q == S_IDLE && dce) || busy;
    assign dout           = dout_q;
    assign dout_valid     = state_q == S_DONE;
    assign bus_err        = expire;
    assign dbus.bus_req   = state_q == S_REQ;
    assign dbus.bus_wr    = wr_q;
    assign dbus.bus_addr  = addr_q;
    assign dbus.bus_wstrb = wstrb_q;
    assign dbus.bus_wdata = wdata_q;
endmodule
